ram_responder: RTL and testbench

//  Memory-side responder for the valid/ready request bus issued by the cache

---
 rtl/ram_responder.sv | 170 +++++++++++++++++
 tb/tb_ram_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// ram_responder: word-organised RAM behind a valid/ready bus, answering after LATENCY wait states.
// Optional build macro RAM_RESP_STATS_EN adds saturating read/write/fetch counters.
module ram_responder_lane #(
  parameter int DEPTH_BITS = 14,
  parameter int VEC_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  re,
  input  logic                  rd_zero,
  input  logic [DEPTH_BITS-1:0] addr,
  input  logic [VEC_W-1:0]      wdata,
  output logic [VEC_W-1:0]      rdata
);
  logic [VEC_W-1:0] mem [2**DEPTH_BITS];

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= rd_zero ? '0 : mem[addr];
  end
endmodule

module ram_responder #(
  parameter int RAM_SIZE_BITS = 14,
  parameter int WIDTH         = 32,
  parameter int LATENCY       = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_valid,
  input  logic             mem_instr,
  input  logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_wdata,
  input  logic [3:0]       mem_wstrb,
`ifdef RAM_RESP_STATS_EN
  output logic [31:0]      stat_reads,
  output logic [31:0]      stat_writes,
  output logic [31:0]      stat_fetches,
`endif
  output logic             mem_ready,
  output logic [WIDTH-1:0] mem_rdata,
  output logic             mem_err
);
  localparam int         NUM_LANES = 4;
  localparam int         VEC_W     = 8;
  localparam logic [3:0] LAT       = 4'(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                          state, state_nx;
  logic [3:0]                      cnt;
  logic [WIDTH-1:0]                addr_q, wdata_q;
  logic [3:0]                      wstrb_q;
  logic                            err_q;
  logic [WIDTH-1:0]                req_addr, req_wdata;
  logic [3:0]                      req_wstrb;
  logic                            req_oor, req_wr, enter_resp, rd_en;
  logic [RAM_SIZE_BITS-1:0]        word;
  logic [NUM_LANES-1:0]            lane_we;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_wdata, lane_rdata;
  logic                            unused_ok;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (mem_valid) state_nx = (LAT == 4'd0) ? S_RESP : S_WAIT;
      S_WAIT: begin
        if (!mem_valid)       state_nx = S_IDLE;
        else if (cnt == 4'd1) state_nx = S_RESP;
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    mem_ready = 1'b0;
    mem_err   = 1'b0;
    if (state == S_RESP) begin
      mem_ready = 1'b1;
      mem_err   = err_q;
    end
  end

  // With zero latency IDLE goes straight to RESP, so the live bus fields feed the RAM.
  assign req_addr   = (state == S_IDLE) ? mem_addr  : addr_q;
  assign req_wdata  = (state == S_IDLE) ? mem_wdata : wdata_q;
  assign req_wstrb  = (state == S_IDLE) ? mem_wstrb : wstrb_q;
  assign req_oor    = |(req_addr >> (RAM_SIZE_BITS + 2));
  assign req_wr     = |req_wstrb;
  assign word       = req_addr[RAM_SIZE_BITS+1:2];
  assign enter_resp = !reset && (state_nx == S_RESP);
  assign rd_en      = enter_resp && !req_wr;
  assign lane_wdata = req_wdata;
  assign mem_rdata  = lane_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_IDLE && mem_valid) begin
        cnt     <= LAT;
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) err_q <= req_oor;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_we[i] = enter_resp && req_wr && !req_oor && req_wstrb[i];
    ram_responder_lane #(.DEPTH_BITS(RAM_SIZE_BITS), .VEC_W(VEC_W)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .we      (lane_we[i]),
      .re      (rd_en),
      .rd_zero (req_oor),
      .addr    (word),
      .wdata   (lane_wdata[i]),
      .rdata   (lane_rdata[i])
    );
  end

`ifdef RAM_RESP_STATS_EN
  logic instr_q;

  always_ff @(posedge clk) begin
    if (reset)                          instr_q <= 1'b0;
    else if (state == S_IDLE && mem_valid) instr_q <= mem_instr;
  end

  // Latched fields are stable throughout RESP, whichever path led there.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_reads   <= '0;
      stat_writes  <= '0;
      stat_fetches <= '0;
    end else if (state == S_RESP) begin
      if (|wstrb_q) begin
        if (stat_writes != '1) stat_writes <= stat_writes + 32'd1;
      end else begin
        if (stat_reads != '1) stat_reads <= stat_reads + 32'd1;
        if (instr_q && stat_fetches != '1) stat_fetches <= stat_fetches + 32'd1;
      end
    end
  end

  assign unused_ok = ^req_addr[1:0];
`else
  assign unused_ok = ^{req_addr[1:0], mem_instr};
`endif
endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: LATENCY=2 and LATENCY=0 instances, scoreboard with a byte-lane RAM model.
module tb_ram_responder;
  localparam int LAT0 = 2;
  localparam int LAT1 = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid [2];
  logic        instr [2];
  logic        ready [2];
  logic        err   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [3:0]  wstrb [2];
`ifdef RAM_RESP_STATS_EN
  logic [31:0] st_rd [2];
  logic [31:0] st_wr [2];
  logic [31:0] st_fe [2];
`endif

  always #5 clk = ~clk;

  ram_responder #(.LATENCY(LAT0)) dut0 (
    .clk(clk), .reset(reset), .mem_valid(valid[0]), .mem_instr(instr[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]),
`ifdef RAM_RESP_STATS_EN
    .stat_reads(st_rd[0]), .stat_writes(st_wr[0]), .stat_fetches(st_fe[0]),
`endif
    .mem_ready(ready[0]), .mem_rdata(rdata[0]), .mem_err(err[0])
  );

  ram_responder #(.LATENCY(LAT1)) dut1 (
    .clk(clk), .reset(reset), .mem_valid(valid[1]), .mem_instr(instr[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]),
`ifdef RAM_RESP_STATS_EN
    .stat_reads(st_rd[1]), .stat_writes(st_wr[1]), .stat_fetches(st_fe[1]),
`endif
    .mem_ready(ready[1]), .mem_rdata(rdata[1]), .mem_err(err[1])
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];
  logic [31:0] last_rd [2];
  bit          after_b2b [2];
  int          ready_cyc [2];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;

  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mget(input int key);
    return model.exists(key) ? model[key] : 32'h0;
  endfunction

  // Called at a negedge; returns at a negedge with the DUT idle (or in RESP if b2b).
  task automatic req(input int d, input string tag, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, input logic ins, input bit b2b, input bit scramble);
    exp_t        e;
    logic [31:0] m;
    int          n, key;
    bit          oor;
    oor   = (a[31:16] != 16'h0);
    key   = d * 65536 + int'(a[15:2]);
    e.tag = tag;
    e.err = oor;
    e.lat = ((d == 0) ? LAT0 : LAT1) + 1 + (after_b2b[d] ? 1 : 0);
    if (ws == 4'h0) begin
      e.rdata    = oor ? 32'h0 : mget(key);
      last_rd[d] = e.rdata;
    end else begin
      e.rdata = last_rd[d];
      if (!oor) begin
        m = mget(key);
        for (int i = 0; i < 4; i++) if (ws[i]) m[8*i +: 8] = wd[8*i +: 8];
        model[key] = m;
      end
    end
    sb.push_back(e);
    valid[d] = 1'b1; addr[d] = a; wdata[d] = wd; wstrb[d] = ws; instr[d] = ins;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (scramble) begin addr[d] = ~a; wdata[d] = ~wd; wstrb[d] = ~ws; end
    end while (!ready[d] && n < 40);
    e = sb.pop_front();
    check({e.tag, "/lat"}, n, e.lat);
    check({e.tag, "/rdata"}, rdata[d], e.rdata);
    check({e.tag, "/err"}, err[d], e.err);
    ready_cyc[d] = cyc;
    after_b2b[d] = b2b;
    if (!b2b) begin
      valid[d] = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic abort_wr(input int d, input string tag, input logic [31:0] a, input logic [31:0] wd);
    int n;
    valid[d] = 1'b1; addr[d] = a; wdata[d] = wd; wstrb[d] = 4'hF; instr[d] = 1'b0;
    @(negedge clk);
    valid[d] = 1'b0;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (ready[d]) n++;
    end
    check({tag, "/no_ready"}, n, 0);
  endtask

  initial begin
    int gap;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0; instr[d] = 1'b0; addr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
      last_rd[d] = '0; after_b2b[d] = 1'b0; ready_cyc[d] = 0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst/ready0", ready[0], 1'b0);
    check("rst/rdata0", rdata[0], 32'h0);
    check("rst/err0",   err[0],   1'b0);
    check("rst/ready1", ready[1], 1'b0);
    check("rst/rdata1", rdata[1], 32'h0);

    req(0, "wr_full",  32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1'b0);
    req(0, "rd_full",  32'h10, 32'h0,        4'h0, 1'b0, 1'b0, 1'b0);
    check("rd_full/const", last_rd[0], 32'hDEADBEEF);
    req(0, "wr_byte0", 32'h10, 32'h000000AA, 4'b0001, 1'b0, 1'b0, 1'b0);
    req(0, "rd_byte0", 32'h10, 32'h0,        4'h0, 1'b0, 1'b0, 1'b0);
    check("rd_byte0/const", last_rd[0], 32'hDEADBEAA);
    req(0, "wr_odd",   32'h13, 32'h12345678, 4'b1010, 1'b0, 1'b0, 1'b0);
    req(0, "rd_odd",   32'h10, 32'h0,        4'h0, 1'b0, 1'b0, 1'b0);
    check("rd_odd/const", last_rd[0], 32'h12AD56AA);

    req(0, "wr_20",    32'h20, 32'h11111111, 4'hF, 1'b0, 1'b0, 1'b0);
    abort_wr(0, "abort", 32'h20, 32'h22222222);
    req(0, "rd_20",    32'h20, 32'h0,        4'h0, 1'b0, 1'b0, 1'b0);

    req(0, "oor_wr",   32'h0001_0010, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0, 1'b0);
    req(0, "oor_rd",   32'h0001_0000, 32'h0,        4'h0, 1'b0, 1'b0, 1'b0);
    req(0, "oor_keep", 32'h10,        32'h0,        4'h0, 1'b0, 1'b0, 1'b0);

    req(0, "scramble", 32'h20, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);

    req(1, "l0_wr",    32'h40, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 1'b0);
    req(1, "l0_rd",    32'h40, 32'h0,        4'h0, 1'b0, 1'b0, 1'b0);
    req(1, "l0_b2b_a", 32'h40, 32'h0,        4'h0, 1'b0, 1'b1, 1'b0);
    gap = ready_cyc[1];
    req(1, "l0_b2b_b", 32'h44, 32'h5A5A5A5A, 4'hF, 1'b0, 1'b0, 1'b0);
    check("l0_b2b/gap", ready_cyc[1] - gap, 2);

    // Reset lands while the write to 0x10 is still waiting.
    valid[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'h0; wstrb[0] = 4'hF;
    @(negedge clk);
    reset = 1'b1; valid[0] = 1'b0;
    @(negedge clk);
    check("midrst/ready", ready[0], 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst/rdata", rdata[0], 32'h0);
    check("midrst/ready2", ready[0], 1'b0);
    last_rd[0] = '0; last_rd[1] = '0; after_b2b[1] = 1'b0;
    req(0, "midrst_rd", 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);

`ifdef RAM_RESP_STATS_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    check("st/rst_rd", st_rd[0], 32'd0);
    for (int i = 0; i < 3; i++) req(0, "st_fetch", 32'h10, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) req(0, "st_read",  32'h20, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    req(0, "st_write", 32'h30, 32'h01020304, 4'hF, 1'b0, 1'b0, 1'b0);
    abort_wr(0, "st_abort", 32'h30, 32'hFFFF0000);
    check("st/reads",   st_rd[0], 32'd5);
    check("st/fetches", st_fe[0], 32'd3);
    check("st/writes",  st_wr[0], 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("st/clr_rd", st_rd[0], 32'd0);
    check("st/clr_fe", st_fe[0], 32'd0);
    check("st/clr_wr", st_wr[0], 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
